// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter with a valid/ready load port. A new word can be
// accepted on the final-bit edge, so consecutive words stream with no idle cycle.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] data,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             at_last;
  logic             accept;

  // Move the register one place toward the output end, filling with zero.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    if (MSB_FIRST) return {v[WIDTH-2:0], 1'b0};
    else           return {1'b0, v[WIDTH-1:1]};
  endfunction

  assign at_last    = (state == SHIFT) && (cnt == CNT_LAST);
  assign load_ready = !clear && ((state == IDLE) || at_last);
  assign accept     = load_valid && load_ready;

  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (at_last) state_nxt = accept ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sout       = 1'b0;
    sout_valid = 1'b0;
    last       = 1'b0;
    busy       = 1'b0;
    if (state == SHIFT) begin
      sout       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
      sout_valid = 1'b1;
      last       = at_last;
      busy       = 1'b1;
    end
  end

  // Clear also wipes the word in flight so an aborted word leaves no residue.
  always_ff @(posedge clk) begin
    if (clear) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (accept) begin
      shreg <= data;
      cnt   <= '0;
    end else if (at_last) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      shreg <= shift_once(shreg);
      cnt   <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: an MSB-first and an LSB-first instance,
// each checked every cycle against a queue of expected serial bits.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       clear;
  logic [3:0] data0, data1;
  logic       lv0, lv1;
  logic       lr0, lr1;
  logic       so0, so1, sv0, sv1, la0, la1, bz0, bz1;

  int errors = 0;
  int checks = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .clear(clear), .data(data0), .load_valid(lv0), .load_ready(lr0),
    .sout(so0), .sout_valid(sv0), .last(la0), .busy(bz0)
  );

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .clear(clear), .data(data1), .load_valid(lv1), .load_ready(lr1),
    .sout(so1), .sout_valid(sv1), .last(la1), .busy(bz1)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic push_msb(input logic [3:0] w);
    for (int i = 0; i < 4; i++) q0.push_back({w[3-i], (i == 3)});
  endtask

  task automatic push_lsb(input logic [3:0] w);
    for (int i = 0; i < 4; i++) q1.push_back({w[i], (i == 3)});
  endtask

  // Advance one edge, then compare both instances against their scoreboards.
  task automatic tick();
    logic [1:0] p;
    bit         e;
    @(posedge clk);
    #1;
    e = (q0.size() != 0);
    chk("msb_valid", sv0, e);
    chk("msb_busy", bz0, e);
    if (e) begin
      p = q0.pop_front();
      chk("msb_sout", so0, p[1]);
      chk("msb_last", la0, p[0]);
    end else begin
      chk("msb_idle_sout", so0, 1'b0);
      chk("msb_idle_last", la0, 1'b0);
    end
    e = (q1.size() != 0);
    chk("lsb_valid", sv1, e);
    chk("lsb_busy", bz1, e);
    if (e) begin
      p = q1.pop_front();
      chk("lsb_sout", so1, p[1]);
      chk("lsb_last", la1, p[0]);
    end else begin
      chk("lsb_idle_sout", so1, 1'b0);
      chk("lsb_idle_last", la1, 1'b0);
    end
  endtask

  task automatic chk_lr(input string tag, input logic exp);
    #1;
    chk(tag, lr0, exp);
  endtask

  initial begin
    clear = 1'b1;
    data0 = 4'b0000; lv0 = 1'b0;
    data1 = 4'b0000; lv1 = 1'b0;

    // Reset state, load_ready held low while clear is asserted
    tick();
    tick();
    chk_lr("ready_in_clear", 1'b0);
    clear = 1'b0;
    chk_lr("ready_after_clear", 1'b1);

    // Single word 1010, MSB first
    data0 = 4'b1010; lv0 = 1'b1; push_msb(4'b1010);
    tick();
    lv0 = 1'b0;
    chk_lr("single_ready_b1", 1'b0);
    tick(); tick(); tick();
    tick();
    chk_lr("single_ready_idle", 1'b1);

    // Back-to-back 1110 then 1000 held valid
    data0 = 4'b1110; lv0 = 1'b1; push_msb(4'b1110);
    tick();
    data0 = 4'b1000;
    chk_lr("b2b_ready_b1", 1'b0);
    tick();
    chk_lr("b2b_ready_b2", 1'b0);
    tick();
    chk_lr("b2b_ready_b3", 1'b0);
    tick();
    chk_lr("b2b_ready_b4", 1'b1);
    push_msb(4'b1000);
    tick();
    lv0 = 1'b0;
    tick(); tick(); tick();
    tick();

    // Loads offered while not ready are ignored
    data0 = 4'b1010; lv0 = 1'b1; push_msb(4'b1010);
    tick();
    data0 = 4'b0101;
    chk_lr("ign_ready_b1", 1'b0);
    tick();
    chk_lr("ign_ready_b2", 1'b0);
    tick();
    chk_lr("ign_ready_b3", 1'b0);
    lv0 = 1'b0;
    tick();
    tick();

    // Clear mid-word aborts, next word serializes cleanly
    data0 = 4'b1110; lv0 = 1'b1; push_msb(4'b1110);
    tick();
    lv0 = 1'b0;
    tick();
    clear = 1'b1;
    q0.delete();
    chk_lr("midclr_ready", 1'b0);
    tick();
    clear = 1'b0;
    chk_lr("midclr_ready_after", 1'b1);
    data0 = 4'b1000; lv0 = 1'b1; push_msb(4'b1000);
    tick();
    lv0 = 1'b0;
    tick(); tick(); tick();
    tick();

    // Clear together with an offered word drops the word
    clear = 1'b1; data0 = 4'b1111; lv0 = 1'b1;
    data1 = 4'b1111; lv1 = 1'b1;
    tick();
    clear = 1'b0; lv0 = 1'b0; lv1 = 1'b0;
    tick();
    tick();

    // LSB-first instance, word 1010
    data1 = 4'b1010; lv1 = 1'b1; push_lsb(4'b1010);
    tick();
    lv1 = 1'b0;
    tick(); tick(); tick();
    tick();
    #1;
    chk("lsb_ready_idle", lr1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
